// File: rtl/flash_fetch.sv
// Multi-byte fetch sequencer: walks the single-byte SPI flash reader across 1-4
// consecutive addresses and returns the bytes packed little-endian with a valid pulse.
module flash_fetch #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [10:0] fetch_addr,
  input  logic [1:0]  fetch_len,
  output logic        fetch_busy,
  output logic        fetch_valid,
  output logic [31:0] fetch_data,
  output logic        fetch_err,
  output logic [10:0] flash_addr,
  output logic        flash_enable,
  input  logic [7:0]  flash_byte,
  input  logic        flash_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_STORE, S_GAP, S_DONE
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t      state_q, state_d;
  logic [10:0] base_q, base_d;
  logic [1:0]  rem_q, rem_d;
  logic [1:0]  idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [10:0] addr_q, addr_d;
  logic        timed_out;

  // Timer value is the number of ARM/WAIT cycles already spent on this byte
  assign timed_out = TIMEOUT_EN && (timer_q == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fetch_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_ARM;
      S_ARM: begin
        if (timed_out)         state_d = S_DONE;
        else if (!flash_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timed_out)        state_d = S_DONE;
        else if (flash_ready) state_d = S_STORE;
      end
      S_STORE: state_d = (idx_q == rem_q) ? S_DONE : S_GAP;
      S_GAP:   if (gap_q == GAP_LAST) state_d = S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address is computed on entry to ISSUE so it is stable with the enable edge;
  // the byte is latched on the WAIT->STORE edge while the reader still presents it.
  always_comb begin
    base_d  = base_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    data_d  = data_q;
    err_d   = err_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_req) begin
          base_d = fetch_addr;
          rem_d  = fetch_len;
          idx_d  = 2'd0;
          data_d = '0;
          err_d  = 1'b0;
          addr_d = fetch_addr;
        end
      end
      S_ISSUE: timer_d = '0;
      S_ARM, S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (timed_out) begin
          err_d = 1'b1;
        end else if (state_q == S_WAIT && flash_ready) begin
          data_d[8*idx_q +: 8] = flash_byte;
        end
      end
      S_STORE: begin
        gap_d = '0;
        if (idx_q != rem_q) idx_d = idx_q + 2'd1;
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) addr_d = base_q + {9'b0, idx_q};
      end
      default: ;
    endcase
  end

  always_comb begin
    flash_enable = 1'b0;
    fetch_busy   = 1'b0;
    fetch_valid  = 1'b0;
    case (state_q)
      S_ISSUE, S_ARM, S_WAIT: begin
        flash_enable = 1'b1;
        fetch_busy   = 1'b1;
      end
      S_STORE, S_GAP: fetch_busy = 1'b1;
      S_DONE:         fetch_valid = 1'b1;
      default: ;
    endcase
  end

  assign flash_addr = addr_q;
  assign fetch_data = data_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_flash_fetch.sv
// Bench for flash_fetch: sticky-ready flash model plus a scoreboard of expected
// results and issued addresses, checked by independent monitors.
module tb_flash_fetch;
  localparam int GAP      = 2;
  localparam int TMO      = 100;
  localparam int READ_LAT = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [10:0] fetch_addr = '0;
  logic [1:0]  fetch_len = '0;
  logic        fetch_busy, fetch_valid, fetch_err, flash_enable;
  logic [31:0] fetch_data;
  logic [10:0] flash_addr;
  logic [7:0]  flash_byte = 8'h00;
  logic        flash_ready = 1'b0;

  always #5 clk = ~clk;

  flash_fetch #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_len(fetch_len),
    .fetch_busy(fetch_busy), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data), .fetch_err(fetch_err),
    .flash_addr(flash_addr), .flash_enable(flash_enable),
    .flash_byte(flash_byte), .flash_ready(flash_ready)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;
  logic [32:0] exp_q[$];
  logic [10:0] addr_q[$];

  // flash model state
  logic        en_prev = 1'b0;
  logic [10:0] cur_addr = '0;
  int  cnt = 0;
  int  stale_cnt = 0;
  int  low_cnt = 1000;
  int  hang_addr = -1;
  bit  pending = 1'b0;
  bit  hang = 1'b0;
  bit  stale_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : flash_model
    if (flash_enable && !en_prev) begin
      if (addr_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_enable: got rise at addr %h, expected none", flash_addr);
      end else begin
        check("flash_addr", 32'(flash_addr), 32'(addr_q.pop_front()));
      end
      check("gap_low", 32'(low_cnt >= GAP), 32'd1);
      cur_addr   = flash_addr;
      cnt        = 0;
      pending    = 1'b1;
      hang       = (int'(flash_addr) == hang_addr);
      flash_byte = 8'hEE;
      if (stale_mode) stale_cnt = 3;
      else            flash_ready = 1'b0;
    end else if (stale_cnt > 0) begin
      stale_cnt--;
      if (stale_cnt == 0) flash_ready = 1'b0;
    end else if (pending) begin
      cnt++;
      if (cnt >= READ_LAT && !hang) begin
        flash_ready = 1'b1;
        flash_byte  = cur_addr[7:0] ^ 8'h5A;
        pending     = 1'b0;
      end
    end
    low_cnt = flash_enable ? 0 : low_cnt + 1;
    en_prev = flash_enable;
  end

  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (fetch_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_valid: got data %h, expected no pulse", fetch_data);
      end else begin
        e = exp_q.pop_front();
        check("fetch_data", fetch_data, e[31:0]);
        check("fetch_err", 32'(fetch_err), 32'(e[32]));
      end
      check("enable_at_valid", 32'(flash_enable), 32'd0);
      check("busy_at_valid", 32'(fetch_busy), 32'd0);
      check("addrs_all_issued", 32'(addr_q.size()), 32'd0);
    end
  end

  task automatic start_fetch(input logic [10:0] a, input logic [1:0] l,
                             input logic [31:0] d, input logic err);
    for (int i = 0; i <= int'(l); i++) addr_q.push_back(a + 11'(i));
    exp_q.push_back({err, d});
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = a;
    fetch_len  = l;
    @(negedge clk);
    fetch_req = 1'b0;
    check("busy_after_req", 32'(fetch_busy), 32'd1);
    check("enable_in_issue", 32'(flash_enable), 32'd1);
  endtask

  task automatic do_fetch(input logic [10:0] a, input logic [1:0] l,
                          input logic [31:0] d, input logic err, input int ign_at);
    int start;
    int k;
    start = n_valid;
    start_fetch(a, l, d, err);
    k = 0;
    while (n_valid == start && k < 3000) begin
      if (k == ign_at) begin
        fetch_req = 1'b1; fetch_addr = 11'h3FF; fetch_len = 2'd3;
      end else begin
        fetch_req = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    fetch_req = 1'b0;
    if (k >= 3000) begin
      n_vec++;
      n_err++;
      $display("FAIL fetch_timeout: got no valid for addr %h, expected one", a);
      exp_q.delete();
      addr_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(fetch_busy),   32'd0);
    check({tag, "_valid"},  32'(fetch_valid),  32'd0);
    check({tag, "_data"},   fetch_data,        32'd0);
    check({tag, "_err"},    32'(fetch_err),    32'd0);
    check({tag, "_faddr"},  32'(flash_addr),   32'd0);
    check({tag, "_enable"}, 32'(flash_enable), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int k;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_fetch(11'h010, 2'd0, 32'h0000004A, 1'b0, -1);
    do_fetch(11'h100, 2'd3, 32'h59585B5A, 1'b0, 20);
    do_fetch(11'h7FE, 2'd2, 32'h005AA5A4, 1'b0, -1);

    stale_mode = 1'b1;
    do_fetch(11'h033, 2'd1, 32'h00006E69, 1'b0, -1);
    stale_mode = 1'b0;

    hang_addr = 32'h021;
    do_fetch(11'h020, 2'd1, 32'h0000007A, 1'b1, -1);
    hang_addr = -1;

    // abort during the second byte's WAIT
    start_fetch(11'h200, 2'd3, 32'h0, 1'b0);
    k = 0;
    while (addr_q.size() > 2 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("reach_byte2", 32'(addr_q.size()), 32'd2);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    addr_q.delete();
    check_all_zero("midreset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_fetch(11'h055, 2'd1, 32'h00000C0F, 1'b0, -1);

    repeat (20) @(negedge clk);
    check("valid_count", 32'(n_valid), 32'd6);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
